// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes, register typedefs and the writable-address rule shared by the register file.
package regfile_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int ZERO_ADDR = 0;

    typedef logic [$clog2(DEF_NREGS)-1:0] reg_addr_t;
    typedef logic [DEF_XLEN-1:0]          reg_data_t;

    // An address accepts writes and issues only inside the array and, with a hardwired zero, not at x0.
    function automatic logic writable(input int addr, input int nregs, input logic zero_reg);
        return (addr < nregs) && !(zero_reg && addr == ZERO_ADDR);
    endfunction
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register busy bits (issue sets, writeback clears, set wins) and registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS    = DEF_NREGS,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    // Count is taken from the next-state vector so it tracks busy in the same cycle.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (iss_valid && writable(32'(iss_rd), NREGS, ZERO_REG != 0)) busy_d[iss_rd] = 1'b1;
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NRD combinational read ports, one writeback port and a RAW busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; otherwise reads see the pre-write value.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NREGS    = DEF_NREGS,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NRD-1:0]              ren,
    input  logic [NRD-1:0][AW-1:0]      raddr,
    output logic [NRD-1:0][XLEN-1:0]    rdata,
    output logic [NRD-1:0]              rbusy,
    output logic                        stall,
    input  logic                        wen,
    input  logic [AW-1:0]               waddr,
    input  logic [XLEN-1:0]             wdata,
    input  logic                        iss_valid,
    input  logic [AW-1:0]               iss_rd,
    output logic [AW:0]                 busy_cnt,
    output logic [NREGS-1:0][XLEN-1:0]  data
);
    logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
    logic [NREGS-1:0]           busy;
    logic                       w_ok;

    assign w_ok = wen && writable(32'(waddr), NREGS, ZERO_REG != 0);

    regfile_scoreboard #(.NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_en    (w_ok),
        .clr_addr  (waddr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    // x0 is never written, so it keeps its reset value of zero without a read-side special case.
    always_comb begin
        rf_d = rf_q;
        if (w_ok) rf_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rf_q <= '0;
        else        rf_q <= rf_d;
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata[i] = (ren[i] && 32'(raddr[i]) < NREGS) ? rf_q[raddr[i]] : '0;
            rbusy[i] = ren[i] && 32'(raddr[i]) < NREGS && busy[raddr[i]];
`ifdef REGFILE_BYPASS_EN
            if (ren[i] && w_ok && raddr[i] == waddr) begin
                rdata[i] = wdata;
                rbusy[i] = 1'b0;
            end
`endif
        end
    end

    assign stall = |rbusy;
    assign data  = rf_q;
endmodule
